// File: rtl/mesh_pkg.sv
// Shared mesh router constants: flit width default, port indices and VC encoding.
package mesh_pkg;

  localparam int unsigned DEFAULT_PACKET_WIDTH = 64;
  localparam int unsigned NUM_PORTS            = 5;

  localparam int unsigned PORT_CW  = 0;
  localparam int unsigned PORT_CCW = 1;
  localparam int unsigned PORT_NS  = 2;
  localparam int unsigned PORT_SN  = 3;
  localparam int unsigned PORT_PE  = 4;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

  function automatic vc_e other_vc(input vc_e v);
    return (v == VC_EVEN) ? VC_ODD : VC_EVEN;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request after ptr_i, with wrap.
module rr_arbiter
  import mesh_pkg::*;
#(
  parameter int unsigned NUM_IN = NUM_PORTS,
  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand_idx = '0;
    // Offsets 1..NUM_IN so the last-granted input is considered last.
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      cand_idx = IDX_W'((32'(ptr_i) + k) % NUM_IN);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_out_arbiter.sv
// Per-output-port arbiter with a two-entry (even/odd VC) output buffer.
// Optional stall counter output enabled by defining MESH_ARB_STALL_CNT_EN.
module mesh_out_arbiter
  import mesh_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int unsigned NUM_IN       = NUM_PORTS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           polarity,
  input  logic [NUM_IN-1:0]              req,
  input  logic [NUM_IN*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_IN-1:0]              gnt,
  output logic                           so,
  input  logic                           ro,
`ifdef MESH_ARB_STALL_CNT_EN
  output logic [15:0]                    stall_cnt,
`endif
  output logic [PACKET_WIDTH-1:0]        do_o
);

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [PACKET_WIDTH-1:0] buf_q [2];
  logic [PACKET_WIDTH-1:0] buf_d [2];
  logic [1:0]              full_q, full_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;

  vc_e                     int_vc, ext_vc;
  logic [NUM_IN-1:0]       arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    grant_en;
  logic [PACKET_WIDTH-1:0] req_flit [NUM_IN];

  assign int_vc = vc_e'(polarity);
  assign ext_vc = other_vc(int_vc);

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      req_flit[i] = req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

  rr_arbiter #(.NUM_IN(NUM_IN)) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Gating with reset keeps gnt/so quiet while reset is held, not just after it.
  assign grant_en = reset & ~full_q[int_vc] & (|req);
  assign gnt      = grant_en ? arb_gnt : '0;
  assign so       = reset & full_q[ext_vc] & ro;
  assign do_o     = so ? buf_q[ext_vc] : '0;

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    ptr_d  = ptr_q;
    if (so) begin
      full_d[ext_vc] = 1'b0;
    end
    if (grant_en) begin
      buf_d[int_vc]  = req_flit[arb_idx];
      full_d[int_vc] = 1'b1;
      ptr_d          = arb_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      full_q   <= '0;
      ptr_q    <= IDX_W'(NUM_IN - 1);
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      full_q   <= full_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef MESH_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((|req) && full_q[int_vc] && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mesh_out_arbiter.sv
// Directed self-checking bench for mesh_out_arbiter (define MESH_ARB_STALL_CNT_EN for the counter checks).
module tb_mesh_out_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         polarity;
  logic         ro;
  logic [4:0]   req;
  logic [63:0]  dat [5];
  logic [319:0] req_data;
  logic [4:0]   gnt;
  logic         so;
  logic [63:0]  dout;
`ifdef MESH_ARB_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 5; i++) req_data[i*64 +: 64] = dat[i];
  end

  mesh_out_arbiter #(.PACKET_WIDTH(64), .NUM_IN(5)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .polarity  (polarity),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .so        (so),
    .ro        (ro),
`ifdef MESH_ARB_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .do_o      (dout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic restore_data();
    for (int i = 0; i < 5; i++) dat[i] = 64'h100 + 64'(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] eg;
    rst_n    = 1'b0;
    polarity = 1'b0;
    req      = 5'b11111;
    ro       = 1'b1;
    restore_data();

    // Reset held with everything requesting
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_so", 64'(so), 64'h0);
    chk("rst_do", dout, 64'h0);
`ifdef MESH_ARB_STALL_CNT_EN
    chk("rst_stall", 64'(stall_cnt), 64'h0);
`endif

    // Fairness: release with polarity 0, all five requesting
    rst_n = 1'b1;
    #1;
    chk("fair_gnt0", 64'(gnt), 64'h1);
    chk("fair_so0", 64'(so), 64'h0);
    chk("fair_do0", dout, 64'h0);
    for (int k = 1; k < 10; k++) begin
      cyc();
      #1;
      eg = 5'b1 << (k % 5);
      chk("fair_gnt", 64'(gnt), 64'(eg));
      chk("fair_so", 64'(so), 64'h1);
      chk("fair_do", dout, 64'h100 + 64'((k - 1) % 5));
    end
    cyc();
    req = 5'b0;
    #1;
    chk("fair_tail_gnt", 64'(gnt), 64'h0);
    chk("fair_tail_so", 64'(so), 64'h1);
    chk("fair_tail_do", dout, 64'h104);
    cyc();
    #1;
    chk("fair_idle_so", 64'(so), 64'h0);
    chk("fair_idle_do", dout, 64'h0);

    // Single flit
    cyc();
    req    = 5'b00100;
    dat[2] = 64'hA5;
    #1;
    chk("single_gnt", 64'(gnt), 64'h4);
    cyc();
    req = 5'b0;
    #1;
    chk("single_so", 64'(so), 64'h1);
    chk("single_do", dout, 64'hA5);
    cyc();
    #1;
    chk("single_after_so", 64'(so), 64'h0);
    chk("single_after_do", dout, 64'h0);
    restore_data();

    // Backpressure on VC0
    cyc();
    cyc();
    req    = 5'b00001;
    dat[0] = 64'h1;
    ro     = 1'b0;
    #1;
    chk("bp_fill_gnt", 64'(gnt), 64'h1);
    for (int j = 0; j < 6; j++) begin
      cyc();
      req = polarity ? 5'b00000 : 5'b00001;
      #1;
      chk("bp_so", 64'(so), 64'h0);
      chk("bp_do", dout, 64'h0);
      if (!polarity) chk("bp_gnt", 64'(gnt), 64'h0);
    end
    cyc();
    req = 5'b0;
    ro  = 1'b1;
    #1;
    chk("bp_release_so", 64'(so), 64'h1);
    chk("bp_release_do", dout, 64'h1);
    cyc();
    req = 5'b00001;
    #1;
    chk("bp_regrant_gnt", 64'(gnt), 64'h1);
    chk("bp_regrant_so", 64'(so), 64'h0);

    // Mid-operation reset with both VCs full
    cyc();
    req = 5'b00010;
    ro  = 1'b0;
    #1;
    chk("mid_fill_gnt", 64'(gnt), 64'h2);
    cyc();
    req   = 5'b0;
    ro    = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_so", 64'(so), 64'h0);
    chk("mid_rst_do", dout, 64'h0);
    chk("mid_rst_gnt", 64'(gnt), 64'h0);
    cyc();
    rst_n = 1'b1;
    restore_data();
    #1;
    chk("mid_post_so1", 64'(so), 64'h0);
    chk("mid_post_do1", dout, 64'h0);
    cyc();
    req = 5'b11111;
    #1;
    chk("mid_post_so0", 64'(so), 64'h0);
    chk("mid_post_gnt", 64'(gnt), 64'h1);
    cyc();
    req = 5'b0;
    #1;
    chk("mid_post_send_so", 64'(so), 64'h1);
    chk("mid_post_send_do", dout, 64'h100);
    cyc();
    #1;
    chk("mid_post_idle_so", 64'(so), 64'h0);
    chk("mid_post_idle_do", dout, 64'h0);

`ifdef MESH_ARB_STALL_CNT_EN
    // Stall counter: VC0 full, ro low, requests on polarity-0 cycles only
    cyc();
    cyc();
    req = 5'b00001;
    ro  = 1'b0;
    for (int j = 0; j < 16; j++) begin
      cyc();
      req = polarity ? 5'b00000 : 5'b00001;
    end
    cyc();
    req = 5'b00001;
    #1;
    chk("stall_8", 64'(stall_cnt), 64'd8);
    for (int j = 0; j < 65530; j++) begin
      cyc();
      req = 5'b11111;
    end
    #1;
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
